hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the in-order core; sits beside the IF/ID/EX stages.
- Detects load-use hazards and inserts a one-cycle bubble into ID/EX.
- Freezes the front end while a multi-cycle FPU operation (divide/sqrt) occupies EX.
- Gates PC redirects and squashes the wrong-path fetch on taken jumps/branches resolved in ID.
- Drives the existing stall inputs of the PC, IF/ID and ID/EX registers, plus new flush inputs.

Parameters:
- REGFILE_LEN, 6, register index width (0-31 integer, 32-63 FP; only index 0 is hard-wired zero).
- FPU_OP_WIDTH, 5, width of the fpu_op field.
- FPU_LONG_LAT, 8, total EX residency in cycles of a long FPU op; legal range 3..255.
- STALL_CNT_WIDTH, 32, width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: one clock, synchronous, active-high.
- id_rs1  in  REGFILE_LEN  source 1 index of the instruction in ID.
- id_rs2  in  REGFILE_LEN  source 2 index of the instruction in ID.
- ex_rd  in  REGFILE_LEN  destination index of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_alu_fpu  in  1  EX instruction uses the FPU.
- ex_fpu_op  in  FPU_OP_WIDTH  FPU opcode of the EX instruction.
- imm_pc  in  1  ID requests a PC redirect (jump/taken branch).
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID register.
- id_ex_stall  out  1  hold ID/EX register.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load bubble (all controls 0) into ID/EX.
- pc_redirect  out  1  qualified redirect; if_stage takes next_imm_pc only when this is 1.
- fpu_busy  out  1  long FPU op in progress.
- stall_cycles  out  STALL_CNT_WIDTH  count of cycles with pc_stall=1.

Behaviour:
- Reset: state=IDLE, cnt=0, stall_cycles=0. While rst=1, every stall/flush output, pc_redirect and fpu_busy are 0. Reset mid-FPU-op returns to IDLE on the next edge with no residual stall.
- The state machine has three states: IDLE, BUSY and DONE. cnt is an 8-bit register.
- long_op = ex_alu_fpu & (ex_fpu_op==FPU_OP_DIV | ex_fpu_op==FPU_OP_SQRT).
- lu_hazard = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2). The comparison uses the full 6-bit index, so FP loads hazard FP sources.
- IDLE, long_op=1 (cycle T0):
  - Combinationally assert pc_stall, if_id_stall, id_ex_stall and fpu_busy.
  - Next state BUSY, cnt <= FPU_LONG_LAT-3.
- IDLE, lu_hazard=1:
  - Assert pc_stall, if_id_stall and id_ex_flush for exactly one cycle.
  - State stays IDLE; next cycle the bubble is in EX, so no hazard remains.
- long_op and lu_hazard are mutually exclusive (EX holds one instruction). If both are asserted, long_op wins.
- BUSY:
  - Assert all three stalls and fpu_busy.
  - If cnt==0, go to DONE; else cnt <= cnt-1.
  - lu_hazard is ignored.
- DONE:
  - All stalls deasserted; the FPU result is valid and EX advances at the end of this cycle.
  - long_op is ignored in this state (the same instruction is still in EX).
  - lu_hazard is evaluated normally.
  - Next state IDLE.
- Timing: total EX residency = 1 + (FPU_LONG_LAT-2) + 1 = FPU_LONG_LAT cycles. Back-to-back long ops re-trigger on the IDLE cycle after DONE.
- Redirect rules:
  - pc_redirect = imm_pc & ~pc_stall.
  - if_id_flush = imm_pc & ~pc_stall.
  - While stalled, the jump in ID is held and re-presents imm_pc when the stall releases. No redirect is lost or duplicated.
- Simultaneous imm_pc and lu_hazard: stall wins; redirect and flush occur the following cycle.
- stall_cycles increments on every cycle with pc_stall=1 and saturates at all-ones (no wrap).
- All stall/flush outputs are combinational from state plus inputs. Only state, cnt and stall_cycles are registered.

Decomposition:
- hazard_pkg holds:
  - the state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - FPU_OP_DIV=5'd3 and FPU_OP_SQRT=5'd4, shared with the FPU decoder;
  - FPU_LONG_LAT.
- One natural sub-module, fpu_busy_fsm: owns state and cnt, outputs fpu_busy and in_done.
- hazard_ctrl holds the load-use comparator, the output muxing and stall_cycles.

Test Plan:
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rd=5, id_rs2=5.
  - Required: pc_stall=if_id_stall=id_ex_flush=1 for exactly 1 cycle, id_ex_stall=0, stall_cycles=1.
  - Repeat with ex_rd=0 -> no stall.
- FPU divide:
  - Stimulus: ex_alu_fpu=1, ex_fpu_op=3 held, FPU_LONG_LAT=8.
  - Required: fpu_busy and all stalls high for 7 consecutive cycles, low on cycle 8 (DONE), then IDLE; stall_cycles=7.
- Back-to-back sqrt, sqrt:
  - Required: two 7-cycle stall windows separated by exactly one unstalled cycle.
- Jump during FPU busy:
  - Stimulus: imm_pc=1 throughout BUSY.
  - Required: pc_redirect=if_id_flush=0 while stalled; both =1 in the DONE cycle only.
- Reset mid-op:
  - Stimulus: rst=1 for 1 cycle at BUSY cnt=3.
  - Required: all outputs 0 during reset, stall_cycles=0, and a non-FPU instruction in EX afterwards sees no stall.
- Saturation:
  - Stimulus: preload stall_cycles to 32'hFFFFFFFE via a long stall.
  - Required: value holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller and the FPU decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    // FPU sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // Long-latency FPU opcodes, shared with the FPU decoder
    localparam logic [4:0] FPU_OP_DIV  = 5'd3;
    localparam logic [4:0] FPU_OP_SQRT = 5'd4;

    // Total EX residency of a long FPU op, in cycles (legal 3..255)
    localparam int FPU_LONG_LAT = 8;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall/flush outputs are the pipeline's backpressure.
// master: pipeline stages (drive indices/flags, consume stalls/flushes).
// slave : hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REGFILE_LEN     = 6,
    parameter int FPU_OP_WIDTH    = 5,
    parameter int STALL_CNT_WIDTH = 32
);
    logic [REGFILE_LEN-1:0]     id_rs1;
    logic [REGFILE_LEN-1:0]     id_rs2;
    logic [REGFILE_LEN-1:0]     ex_rd;
    logic                       ex_mem_read;
    logic                       ex_alu_fpu;
    logic [FPU_OP_WIDTH-1:0]    ex_fpu_op;
    logic                       imm_pc;
    logic                       pc_stall;
    logic                       if_id_stall;
    logic                       id_ex_stall;
    logic                       if_id_flush;
    logic                       id_ex_flush;
    logic                       pc_redirect;
    logic                       fpu_busy;
    logic [STALL_CNT_WIDTH-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_alu_fpu, ex_fpu_op, imm_pc,
        input  pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
               pc_redirect, fpu_busy, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_alu_fpu, ex_fpu_op, imm_pc,
        output pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
               pc_redirect, fpu_busy, stall_cycles
    );
endinterface

// File: rtl/fpu_busy_fsm.sv
// Tracks EX residency of a long FPU op (divide/sqrt): IDLE -> BUSY -> DONE.
// Latency: fpu_busy_o is combinational on the trigger cycle, then held LONG_LAT-1 cycles total.
// Backpressure: none accepted; the caller turns fpu_busy_o into pipeline stalls.
// Ports: clk, rst (sync, active-high), long_op_i, fpu_busy_o, in_done_o.
module fpu_busy_fsm #(
    parameter int LONG_LAT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic long_op_i,
    output logic fpu_busy_o,
    output logic in_done_o
);
    import hazard_pkg::*;

    // BUSY lasts LONG_LAT-2 cycles: counts CNT_INIT down to 0 inclusive
    localparam logic [7:0] CNT_INIT = 8'(LONG_LAT - 3);

    fsm_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (long_op_i) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            // Same instruction still in EX, so long_op is not re-examined here
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fpu_busy_o = ((state_q == IDLE) && long_op_i) || (state_q == BUSY);
        in_done_o  = (state_q == DONE);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use bubble, long-FPU front-end freeze, redirect qualification.
// Latency: all stall/flush/redirect outputs are combinational from FSM state plus inputs.
// Backpressure: stall wins over redirect; a held jump re-presents imm_pc after release.
// Ports: clk, rst (sync, active-high), bus (hazard_ctrl_if.slave): ID/EX indices and
//        flags in; PC/IF-ID/ID-EX stalls, flushes, pc_redirect, fpu_busy, stall_cycles out.
module hazard_ctrl #(
    parameter int REGFILE_LEN     = 6,
    parameter int FPU_OP_WIDTH    = 5,
    parameter int FPU_LONG_LAT    = hazard_pkg::FPU_LONG_LAT,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    import hazard_pkg::*;

    logic [REGFILE_LEN-1:0]     rs1, rs2, rd;
    logic                       long_op;
    logic                       lu_hazard;
    logic                       lu_act;
    logic                       fsm_busy;
    logic                       in_done;
    logic                       pc_stall;
    logic [STALL_CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.ex_rd;

    assign long_op = bus.ex_alu_fpu &&
                     ((bus.ex_fpu_op == FPU_OP_WIDTH'(FPU_OP_DIV)) ||
                      (bus.ex_fpu_op == FPU_OP_WIDTH'(FPU_OP_SQRT)));

    // Full index compare: FP loads (32..63) hazard FP sources; only x0 is exempt
    assign lu_hazard = bus.ex_mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));

    fpu_busy_fsm #(
        .LONG_LAT (FPU_LONG_LAT)
    ) u_fpu_busy_fsm (
        .clk        (clk),
        .rst        (rst),
        .long_op_i  (long_op),
        .fpu_busy_o (fsm_busy),
        .in_done_o  (in_done)
    );

    // The FPU freeze masks the load-use check (long_op wins, BUSY ignores it);
    // in DONE the EX op is retiring, so the comparator is live again.
    assign lu_act = lu_hazard && (in_done || !fsm_busy);

    assign pc_stall        = !rst && (fsm_busy || lu_act);
    assign bus.pc_stall    = pc_stall;
    assign bus.if_id_stall = pc_stall;
    assign bus.id_ex_stall = !rst && fsm_busy;
    assign bus.id_ex_flush = !rst && lu_act;
    assign bus.fpu_busy    = !rst && fsm_busy;

    // A stalled jump stays in ID and re-asserts imm_pc, so qualifying here
    // neither drops nor duplicates the redirect.
    assign bus.pc_redirect = !rst && bus.imm_pc && !pc_stall;
    assign bus.if_id_flush = !rst && bus.imm_pc && !pc_stall;

    // Saturating count of PC-stall cycles
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (pc_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;

endmodule
